// File: rtl/peripheral_spram_axi4_pkg.sv
// Shared encodings for the SRAM-facing AXI4 read burst engine: burst types,
// response codes, controller states and the burst legality check.
package peripheral_spram_axi4_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // A burst the SRAM cannot serve is answered entirely with SLVERR beats.
  function automatic logic burst_is_err(input logic [1:0] burst,
                                        input logic [2:0] size,
                                        input logic [7:0] len,
                                        input logic [2:0] max_size);
    return (burst == BURST_RSVD) || (size > max_size) ||
           ((burst == BURST_WRAP) && !wrap_len_ok(len));
  endfunction

endpackage

// File: rtl/peripheral_spram_axi4_rfifo.sv
// Synchronous read-data FIFO with occupancy count; a push and a pop in the
// same cycle keep the count unchanged.
module peripheral_spram_axi4_rfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             wr_en;
  logic             rd_en;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/peripheral_spram_axi4_rd_burst.sv
// AXI4 read burst engine in front of a single-port SRAM: expands one AR into
// per-beat SRAM reads and returns the words on R through a credit-checked FIFO.
module peripheral_spram_axi4_rd_burst
  import peripheral_spram_axi4_pkg::*;
#(
  parameter int AXI_ID_WIDTH   = 10,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_USER_WIDTH = 10,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_ar_id,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr,
  input  logic [7:0]                axi_ar_len,
  input  logic [2:0]                axi_ar_size,
  input  logic [1:0]                axi_ar_burst,
  input  logic [AXI_USER_WIDTH-1:0] axi_ar_user,
  input  logic                      axi_ar_valid,
  output logic                      axi_ar_ready,
  output logic [AXI_ID_WIDTH-1:0]   axi_r_id,
  output logic [AXI_DATA_WIDTH-1:0] axi_r_data,
  output logic [1:0]                axi_r_resp,
  output logic                      axi_r_last,
  output logic [AXI_USER_WIDTH-1:0] axi_r_user,
  output logic                      axi_r_valid,
  input  logic                      axi_r_ready,
  output logic                      req_o,
  output logic [AXI_ADDR_WIDTH-1:0] addr_o,
  input  logic [AXI_DATA_WIDTH-1:0] data_i
);
  localparam int AW       = AXI_ADDR_WIDTH;
  localparam int ADDR_LSB = $clog2(AXI_DATA_WIDTH/8);
  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0]      MAX_SIZE   = 3'(ADDR_LSB);
  localparam logic [AW-1:0]   ALIGN_MASK = ~((AW'(1) << ADDR_LSB) - AW'(1));
  localparam logic [CNT_W:0]  CREDIT_LIM = (CNT_W+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [1:0]                resp;
    logic                      last;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  state_e                    state_q;
  state_e                    state_d;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [AXI_USER_WIDTH-1:0] user_q;
  logic                      err_q;
  logic [AW-1:0]             addr_q;
  logic [7:0]                len_q;
  logic [2:0]                size_q;
  logic [1:0]                burst_q;
  logic [7:0]                beat_q;

  logic                      ar_hs;
  logic                      ar_err;
  logic                      issue;
  logic                      beat_last;
  logic                      credit;
  logic [CNT_W:0]            occupancy;

  logic                      vld_p1;
  logic                      last_p1;

  logic                      fifo_push;
  entry_t                    fifo_wentry;
  entry_t                    fifo_head;
  logic [ENTRY_W-1:0]        fifo_rdata;
  logic [CNT_W-1:0]          fifo_count;
  logic                      fifo_empty;
  logic                      r_hs;

  // Beat-to-beat address step; WRAP stays inside a (len+1)<<size window.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a,
                                              input logic [7:0]    len,
                                              input logic [2:0]    size,
                                              input logic [1:0]    burst);
    logic [AW-1:0] step;
    logic [AW-1:0] inc;
    logic [AW-1:0] mask;
    step = AW'(1) << size;
    inc  = a + step;
    mask = ((AW'(len) + AW'(1)) << size) - AW'(1);
    case (burst)
      BURST_FIXED: return a;
      BURST_WRAP:  return (a & ~mask) | (inc & mask);
      default:     return inc;
    endcase
  endfunction

  assign ar_hs     = axi_ar_valid && axi_ar_ready;
  assign ar_err    = burst_is_err(axi_ar_burst, axi_ar_size, axi_ar_len, MAX_SIZE);
  assign beat_last = (beat_q == len_q);
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, vld_p1};
  assign credit    = (occupancy < CREDIT_LIM);
  assign r_hs      = axi_r_valid && axi_r_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ar_hs) state_d = ST_ISSUE;
      ST_ISSUE: if (issue && beat_last) state_d = ST_DRAIN;
      ST_DRAIN: if (r_hs && axi_r_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    axi_ar_ready = 1'b0;
    issue        = 1'b0;
    case (state_q)
      ST_IDLE:  axi_ar_ready = !rst_i;
      ST_ISSUE: issue        = credit && !rst_i;
      default:  ;
    endcase
  end

  assign req_o  = issue && !err_q;
  assign addr_o = req_o ? (addr_q & ALIGN_MASK) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_q   <= '0;
      user_q <= '0;
      err_q  <= 1'b0;
    end else if (ar_hs) begin
      id_q   <= axi_ar_id;
      user_q <= axi_ar_user;
      err_q  <= ar_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (ar_hs) begin
      addr_q  <= axi_ar_addr;
      len_q   <= axi_ar_len;
      size_q  <= axi_ar_size;
      burst_q <= axi_ar_burst;
      beat_q  <= '0;
    end else if (issue) begin
      addr_q  <= next_addr(addr_q, len_q, size_q, burst_q);
      beat_q  <= beat_q + 8'd1;
    end
  end

  // p0 -> p1: SRAM read in flight; its word is on data_i during p1.
  always_ff @(posedge clk_i) begin
    if (rst_i) vld_p1 <= 1'b0;
    else       vld_p1 <= req_o;
  end

  always_ff @(posedge clk_i) begin
    last_p1 <= beat_last;
  end

  // Error beats never touch the SRAM, so they cannot collide with a p1 push.
  always_comb begin
    fifo_wentry = '0;
    if (vld_p1) begin
      fifo_wentry.data = data_i;
      fifo_wentry.resp = RESP_OKAY;
      fifo_wentry.last = last_p1;
    end else begin
      fifo_wentry.resp = RESP_SLVERR;
      fifo_wentry.last = beat_last;
    end
  end

  assign fifo_push = vld_p1 || (issue && err_q);

  peripheral_spram_axi4_rfifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rfifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (fifo_push),
    .wdata (fifo_wentry),
    .pop   (r_hs),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign fifo_head   = entry_t'(fifo_rdata);
  assign axi_r_valid = !fifo_empty;
  assign axi_r_data  = fifo_empty ? '0 : fifo_head.data;
  assign axi_r_resp  = fifo_empty ? RESP_OKAY : fifo_head.resp;
  assign axi_r_last  = !fifo_empty && fifo_head.last;
  assign axi_r_id    = id_q;
  assign axi_r_user  = user_q;

endmodule
